regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/riscv_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file constants and types for the integer core.
package riscv_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result tracking: one bit per register, set on allocate, cleared on write.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_WR-1:0]                we,
  input  logic [N_WR-1:0][ADDR_W-1:0]    waddr,
  input  logic                           alloc,
  input  logic [ADDR_W-1:0]              alloc_addr,
  input  logic [N_RD-1:0][ADDR_W-1:0]    raddr,
  output logic [N_RD-1:0]                pend_next
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Clears first, then the allocate, so an allocate beats a same-cycle write.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < N_WR; w++) begin
      if (we[w]) pend_d[waddr[w]] = 1'b0;
    end
    if (alloc) pend_d[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    pend_next = '0;
    for (int r = 0; r < N_RD; r++) begin
      pend_next[r] = pend_d[raddr[r]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with registered reads, write forwarding and pending scoreboard.
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_WR-1:0]                i_we,
  input  logic [N_WR-1:0][ADDR_W-1:0]    i_waddr,
  input  logic [N_WR-1:0][DATA_W-1:0]    i_wdata,
  input  logic [N_RD-1:0]                i_re,
  input  logic [N_RD-1:0][ADDR_W-1:0]    i_raddr,
  output logic [N_RD-1:0][DATA_W-1:0]    o_rdata,
  output logic [N_RD-1:0]                o_rpend,
  input  logic                           i_alloc,
  input  logic [ADDR_W-1:0]              i_alloc_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (N_RD < 1 || N_WR < 1) begin : g_bad_cfg
      $error("regfile_mp: N_RD and N_WR must both be at least 1");
    end
  endgenerate

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [N_WR-1:0]               wr_ok;
  logic [N_RD-1:0][DATA_W-1:0]   rd_val;
  logic [N_RD-1:0]               pend_next;

  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < N_WR; w++) begin
      wr_ok[w] = i_we[w] && !(ZERO_REG != 0 && i_waddr[w] == '0);
    end
  end

  // Ascending port order: the last non-blocking update (highest index) wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int w = 0; w < N_WR; w++) begin
        if (wr_ok[w]) mem[i_waddr[w]] <= i_wdata[w];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int r = 0; r < N_RD; r++) begin
      rd_val[r] = mem[i_raddr[r]];
      if (BYPASS != 0) begin
        for (int w = 0; w < N_WR; w++) begin
          if (wr_ok[w] && i_waddr[w] == i_raddr[r]) rd_val[r] = i_wdata[w];
        end
      end
      if (ZERO_REG != 0 && i_raddr[r] == '0) rd_val[r] = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (i_we),
    .waddr      (i_waddr),
    .alloc      (i_alloc),
    .alloc_addr (i_alloc_addr),
    .raddr      (i_raddr),
    .pend_next  (pend_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
      o_rpend <= '0;
    end else begin
      for (int r = 0; r < N_RD; r++) begin
        if (i_re[r]) begin
          o_rdata[r] <= rd_val[r];
          o_rpend[r] <= pend_next[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp, with and without write forwarding.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NW-1:0]          we;
  logic [NW-1:0][AW-1:0]  waddr;
  logic [NW-1:0][DW-1:0]  wdata;
  logic [NR-1:0]          re;
  logic [NR-1:0][AW-1:0]  raddr;
  logic                   alloc;
  logic [AW-1:0]          alloc_addr;
  logic [NR-1:0][DW-1:0]  rdata_b1, rdata_b0;
  logic [NR-1:0]          rpend_b1, rpend_b0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata_b1), .o_rpend(rpend_b1),
    .i_alloc(alloc), .i_alloc_addr(alloc_addr)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata_b0), .o_rpend(rpend_b0),
    .i_alloc(alloc), .i_alloc_addr(alloc_addr)
  );

  // Reference state: architectural register values and pending flags.
  logic [DW-1:0] m_reg  [32];
  logic          m_pend [32];
  logic [DW-1:0] exp_b1 [NR];
  logic [DW-1:0] exp_b0 [NR];
  logic          exp_p  [NR];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int r = 0; r < NR; r++) begin
      exp_b1[r] = '0;
      exp_b0[r] = '0;
      exp_p[r]  = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    logic          np [32];
    logic [AW-1:0] a;
    logic [DW-1:0] nb, n0;
    if (rst_n) begin
      for (int i = 0; i < 32; i++) np[i] = m_pend[i];
      for (int w = 0; w < NW; w++) if (we[w]) np[waddr[w]] = 1'b0;
      if (alloc) np[alloc_addr] = 1'b1;
      np[0] = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (re[r]) begin
          a  = raddr[r];
          n0 = m_reg[a];
          nb = n0;
          for (int w = 0; w < NW; w++) if (we[w] && waddr[w] == a) nb = wdata[w];
          if (a == 0) begin
            nb = '0;
            n0 = '0;
          end
          exp_b1[r] = nb;
          exp_b0[r] = n0;
          exp_p[r]  = np[a];
        end
      end
      for (int w = 0; w < NW; w++) if (we[w] && waddr[w] != 0) m_reg[waddr[w]] = wdata[w];
      for (int i = 0; i < 32; i++) m_pend[i] = np[i];
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int r = 0; r < NR; r++) begin
        check($sformatf("rdata_byp[%0d]", r),   rdata_b1[r], exp_b1[r]);
        check($sformatf("rdata_nobyp[%0d]", r), rdata_b0[r], exp_b0[r]);
        check($sformatf("rpend_byp[%0d]", r),   32'(rpend_b1[r]), 32'(exp_p[r]));
        check($sformatf("rpend_nobyp[%0d]", r), 32'(rpend_b0[r]), 32'(exp_p[r]));
      end
    end
  end

  task automatic idle();
    we    = '0;
    re    = '0;
    alloc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < NR; r++) begin
      check($sformatf("%s_rdata_byp[%0d]", tag, r),   rdata_b1[r], '0);
      check($sformatf("%s_rdata_nobyp[%0d]", tag, r), rdata_b0[r], '0);
      check($sformatf("%s_rpend_byp[%0d]", tag, r),   32'(rpend_b1[r]), '0);
      check($sformatf("%s_rpend_nobyp[%0d]", tag, r), 32'(rpend_b0[r]), '0);
    end
  endtask

  initial begin
    idle();
    waddr = '0; wdata = '0; raddr = '0; alloc_addr = '0;
    model_clear();
    rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Write then read one cycle later.
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
    tick(); idle();
    re = 2'b01; raddr[0] = 5'd5;
    tick();
    check("write_read", rdata_b1[0], 32'hDEADBEEF);

    // Same-cycle write and read of a register that held 0.
    idle();
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h12345678;
    re = 2'b01; raddr[0] = 5'd7;
    tick();
    check("bypass_on",  rdata_b1[0], 32'h12345678);
    check("bypass_off", rdata_b0[0], 32'h0);

    // Register 0 ignores writes and allocates.
    idle();
    we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF;
    alloc = 1'b1; alloc_addr = 5'd0;
    re = 2'b01; raddr[0] = 5'd0;
    tick(); idle();
    re = 2'b11; raddr[0] = 5'd0; raddr[1] = 5'd0;
    tick();
    check("zero_rdata", rdata_b1[0], 32'h0);
    check("zero_rpend", 32'(rpend_b1[1]), 32'h0);

    // Two write ports on one address: higher port wins.
    idle();
    we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3; wdata[0] = 32'h1; wdata[1] = 32'h2;
    tick(); idle();
    re = 2'b10; raddr[1] = 5'd3;
    tick();
    check("collision", rdata_b1[1], 32'h2);

    // Scoreboard set, clear, and allocate-beats-write.
    idle();
    alloc = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    re = 2'b01; raddr[0] = 5'd9;
    tick();
    check("sb_alloc_pend", 32'(rpend_b1[0]), 32'h1);
    idle();
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h55;
    tick(); idle();
    re = 2'b01; raddr[0] = 5'd9;
    tick();
    check("sb_clear_pend", 32'(rpend_b1[0]), 32'h0);
    check("sb_clear_data", rdata_b1[0], 32'h55);
    idle();
    alloc = 1'b1; alloc_addr = 5'd9;
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h66;
    re = 2'b01; raddr[0] = 5'd9;
    tick();
    check("sb_alloc_wins_byp",   32'(rpend_b1[0]), 32'h1);
    check("sb_alloc_wins_nobyp", 32'(rpend_b0[0]), 32'h1);
    check("sb_same_data_byp",    rdata_b1[0], 32'h66);
    check("sb_same_data_nobyp",  rdata_b0[0], 32'h55);

    // Outputs hold while read enable is low.
    idle();
    raddr[0] = 5'd3;
    tick();
    check("hold", rdata_b1[0], 32'h66);

    for (int n = 0; n < 600; n++) begin
      we    = NW'($urandom_range(0, 3));
      re    = NR'($urandom_range(0, 3));
      alloc = ($urandom_range(0, 3) == 0);
      alloc_addr = AW'($urandom_range(0, 15));
      for (int w = 0; w < NW; w++) begin
        waddr[w] = AW'($urandom_range(0, 15));
        wdata[w] = $urandom;
      end
      for (int r = 0; r < NR; r++) raddr[r] = AW'($urandom_range(0, 15));
      tick();
    end

    // Reset in the middle of operation.
    idle();
    for (int i = 1; i <= 4; i++) begin
      we = 2'b01; waddr[0] = AW'(i); wdata[0] = 32'h1000 + 32'(i);
      alloc = 1'b1; alloc_addr = AW'(i + 8);
      tick();
    end
    idle();
    re = 2'b11; raddr[0] = 5'd1; raddr[1] = 5'd4;
    tick();
    check("pre_reset_data", rdata_b1[1], 32'h1004);
    idle();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    we = 2'b01; waddr[0] = 5'd2; wdata[0] = 32'hFF;
    alloc = 1'b1; alloc_addr = 5'd2;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    re = 2'b11; raddr[0] = 5'd1; raddr[1] = 5'd2;
    tick();
    check_all_zero("post_reset_a");
    re = 2'b11; raddr[0] = 5'd3; raddr[1] = 5'd4;
    tick();
    check_all_zero("post_reset_b");
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
